// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: per-channel OFF/WAKE/ON clock gating with settle delay, idle auto-gating and ICG latches.
// Optional GATE_STATS_EN adds per-channel saturating gated-cycle counters with synchronous clear.
module clock_gate_ctrl #(
    parameter int NUM_CH   = 3,
    parameter int IDLE_W   = 8,
    parameter int WAKE_DLY = 2
) (
    input  logic                clk,
    input  logic                reset,
`ifdef GATE_STATS_EN
    input  logic                stats_clr,
    output logic [NUM_CH*32-1:0] gated_cycles,
`endif
    input  logic [NUM_CH-1:0]   req,
    input  logic [NUM_CH-1:0]   busy,
    input  logic                force_on,
    input  logic [IDLE_W-1:0]   idle_thresh,
    output logic [NUM_CH-1:0]   gclk,
    output logic [NUM_CH-1:0]   clk_en,
    output logic [NUM_CH-1:0]   ready,
    output logic                all_off
);
    typedef enum logic [1:0] {OFF, WAKE, ON} state_t;
    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [3:0]        wake_q  [NUM_CH];
    logic [3:0]        wake_d  [NUM_CH];
    logic [IDLE_W-1:0] idle_q  [NUM_CH];
    logic [IDLE_W-1:0] idle_d  [NUM_CH];
    logic [NUM_CH-1:0] idle, off_d, en_lat;
    logic              all_off_q;

    assign idle = ~(req | busy | {NUM_CH{force_on}});

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            wake_d[c]  = wake_q[c];
            idle_d[c]  = idle_q[c];
            case (state_q[c])
                OFF: if (req[c] | force_on) begin
                    state_d[c] = WAKE;
                    wake_d[c]  = 4'(WAKE_DLY);
                end
                WAKE: begin
                    wake_d[c] = wake_q[c] - 4'd1;
                    if (wake_q[c] == 4'd1) state_d[c] = ON;
                end
                default: begin
                    // >= so a lowered threshold gates on the very next idle cycle
                    if (!idle[c]) idle_d[c] = '0;
                    else if (idle_thresh != '0 && idle_q[c] >= idle_thresh - 1'b1) begin
                        state_d[c] = OFF;
                        idle_d[c]  = '0;
                    end
                    else if (~&idle_q[c]) idle_d[c] = idle_q[c] + 1'b1;
                end
            endcase
            off_d[c]  = state_d[c] == OFF;
            clk_en[c] = state_q[c] != OFF;
            ready[c]  = state_q[c] == ON;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= OFF;
                wake_q[c]  <= '0;
                idle_q[c]  <= '0;
            end
            all_off_q <= 1'b1;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                wake_q[c]  <= wake_d[c];
                idle_q[c]  <= idle_d[c];
            end
            all_off_q <= &off_d;
        end
    end

    assign all_off = all_off_q;

    // ICG: latch open during clk low so enable changes never cut a high phase
    always_latch begin
        if (reset) en_lat <= '0;
        else if (!clk) en_lat <= clk_en;
    end

    assign gclk = {NUM_CH{clk}} & en_lat;

`ifdef GATE_STATS_EN
    logic [31:0] gated_q [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) gated_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                gated_q[c] <= stats_clr ? '0 :
                              (!clk_en[c] && ~&gated_q[c]) ? gated_q[c] + 32'd1 : gated_q[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) gated_cycles[c*32 +: 32] = gated_q[c];
    end
`endif
endmodule

// File: doc/clock_gate_ctrl.md
Name: clock_gate_ctrl

Overview:
- Parametrised multi-channel clock-gating controller. Each channel owns a small FSM with three states: OFF, WAKE and ON.
- A channel wakes on request, signals readiness after a programmable settle delay, and auto-gates after a programmable run of idle cycles.
- Sits between the accelerator sequencer and the conv/pool/fc compute engines. Drives glitch-free gated clocks (ICG model) and ready handshakes.

Parameters:
- NUM_CH, 3, number of gated channels (1..16).
- IDLE_W, 8, width of idle-threshold and idle counters.
- WAKE_DLY, 2, cycles from clk_en rising to ready asserting (1..15).

Ports:
- clk  input  1  free-running clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_CH  per-channel activity request (level).
- busy  input  NUM_CH  per-channel "engine still working" indication.
- force_on  input  1  global override; holds every channel ON, no auto-gating.
- idle_thresh  input  IDLE_W  consecutive idle cycles before gating; 0 = never auto-gate.
- gclk  output  NUM_CH  gated clocks.
- clk_en  output  NUM_CH  registered enable feeding the gating latch.
- ready  output  NUM_CH  channel clock running and settled.
- all_off  output  1  high when every channel is in OFF.

Behaviour:
- Reset is asynchronous, active-high, clock clk. Reset values:
  - All FSMs go to OFF.
  - clk_en=0, ready=0, gclk=0, all_off=1.
  - Wake and idle counters cleared.
  - Reset asserted mid-operation kills gclk immediately; no drain.
- Gating cell, per channel:
  - en_lat is transparent while clk=0 and holds while clk=1; it is cleared by reset.
  - gclk = clk & en_lat. No gclk glitch may occur for any clk_en change.
- Per-channel FSM; all registers update on posedge clk:
  - OFF: clk_en=0, ready=0. If req|force_on, go to WAKE and load wake_cnt=WAKE_DLY.
  - WAKE: clk_en=1, ready=0. wake_cnt decrements each cycle; at wake_cnt==1 go to ON.
    - ready therefore rises exactly WAKE_DLY cycles after clk_en rises.
    - req dropping during WAKE does not abort; the channel completes to ON.
  - ON: clk_en=1, ready=1.
    - A cycle is idle when req=0, busy=0 and force_on=0. Each idle cycle increments idle_cnt; any non-idle cycle clears it.
    - When idle_cnt+1==idle_thresh on an idle cycle, go to OFF and clear idle_cnt. clk_en and ready drop on that edge.
    - idle_thresh=0: never leave ON unless reset.
    - idle_cnt saturates at all-ones and never wraps.
- Latency:
  - req sampled high in OFF at edge k gives clk_en=1 after edge k.
  - The first gclk high phase is in cycle k+1.
  - ready is high after edge k+WAKE_DLY.
- Simultaneous events:
  - req and the idle expiry cannot coincide, because req makes the cycle non-idle.
  - Reasserting req in the same cycle the channel enters OFF takes effect on the next edge: OFF→WAKE, i.e. a full re-wake.
- Channels are fully independent apart from force_on.
- idle_thresh is sampled every cycle. A change takes effect immediately against the current idle_cnt. If idle_cnt is already >= the new threshold, the channel gates on the next idle cycle.
- all_off is registered: the AND of all per-channel "state==OFF" flags, updated each edge.

Optional Feature:
- Macro GATE_STATS_EN.
- When defined, adds outputs:
  - gated_cycles, NUM_CH×32: per-channel count of edges with clk_en=0, saturating at 0xFFFFFFFF.
  - stats_clr, 1-bit input: synchronous clear of all counters, with priority over increment.
  - Counters reset to 0.
- When undefined: no ports, no counters, and identical behaviour otherwise.

Test Plan:
- Reset, then idle for 10 cycles, req=0 → clk_en=0, gclk flat low, ready=0, all_off=1.
- WAKE_DLY=2, req[0] pulsed for 1 cycle at edge 5 → clk_en[0]=1 after edge 5, ready[0]=1 after edge 7, all_off=0.
- idle_thresh=4, channel 1 ON, req/busy drop at edge 20 → OFF after edge 23 (4th idle cycle); busy blip at edge 22 restarts the count, giving OFF after edge 26.
- idle_thresh=0 or force_on=1 with no activity for 300 cycles → every channel stays ON, ready=1.
- Channel 2 in ON with gclk toggling, reset asserted mid-clk-high → gclk drops to 0 asynchronously; all outputs at reset values.
- GATE_STATS_EN defined, channel 0 OFF for 50 cycles, then stats_clr for 1 cycle → gated_cycles[0]=50, then 0 on the edge after clr.
